// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_pkg;

    localparam int MD_LAT_DEF = 8;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MD_BUSY  = 2'd1,
        MEM_WAIT = 2'd2
    } state_e;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic if_id_flush;
        logic id_ex_en;
        logic id_ex_bubble;
        logic ex_mem_en;
        logic ex_mem_bubble;
        logic mem_wb_bubble;
        logic md_go;
    } ctrl_t;

    localparam ctrl_t CTRL_DEFAULT = '{
        pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b0,
        id_ex_en: 1'b1, id_ex_bubble: 1'b0,
        ex_mem_en: 1'b1, ex_mem_bubble: 1'b0,
        mem_wb_bubble: 1'b0, md_go: 1'b0
    };

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        if (v == 32'hFFFF_FFFF) begin
            return v;
        end else begin
            return v + 32'd1;
        end
    endfunction

endpackage

// File: rtl/md_timer.sv
// Down-counter timing a mult/div occupancy of EX; loaded once on entry, never wraps.
module md_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] value,
    output logic         zero,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] r_cnt;

    // Count register: load has priority, decrement only on request.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= value;
        end else if (dec) begin
            r_cnt <= r_cnt - ONE;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign cnt  = r_cnt;
    assign zero = (r_cnt == '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller: drives pipeline enables/flushes/bubbles for load-use,
// redirects, multi-cycle mult/div and stalled data-memory accesses.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MD_LAT = MD_LAT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rt,
    input  logic        ex_redirect,
    input  logic        ex_md_start,
    input  logic        dmem_req,
    input  logic        dmem_ready,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        if_id_flush,
    output logic        id_ex_en,
    output logic        id_ex_bubble,
    output logic        ex_mem_en,
    output logic        ex_mem_bubble,
    output logic        mem_wb_bubble,
    output logic        md_go,
    output logic [31:0] stall_cnt
);

    localparam int CW = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;
    localparam logic [CW-1:0] MD_LOAD = CW'(MD_LAT - 2);

    state_e        r_state;
    state_e        w_next;
    ctrl_t         w_ctrl;
    logic          w_load;
    logic          w_dec;
    logic          w_md_zero;
    logic [CW-1:0] w_md_cnt;
    logic          w_load_use;
    logic [31:0]   r_stall_cnt;

    md_timer #(.W(CW)) u_md_timer (
        .clk   (clk),
        .reset (reset),
        .load  (w_load),
        .dec   (w_dec),
        .value (MD_LOAD),
        .zero  (w_md_zero),
        .cnt   (w_md_cnt)
    );

    assign w_load_use = ex_mem_read && (ex_rt != 5'd0) &&
                        ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    // Next state and control outputs; reset forces the RUN defaults.
    always_comb begin
        w_ctrl = CTRL_DEFAULT;
        w_next = r_state;
        w_load = 1'b0;
        w_dec  = 1'b0;
        if (reset) begin
            w_next = RUN;
        end else begin
            case (r_state)
                RUN: begin
                    if (dmem_req && !dmem_ready) begin
                        w_ctrl.pc_en         = 1'b0;
                        w_ctrl.if_id_en      = 1'b0;
                        w_ctrl.id_ex_en      = 1'b0;
                        w_ctrl.ex_mem_en     = 1'b0;
                        w_ctrl.mem_wb_bubble = 1'b1;
                        w_next               = MEM_WAIT;
                    end else if (ex_md_start) begin
                        w_ctrl.md_go         = 1'b1;
                        w_ctrl.pc_en         = 1'b0;
                        w_ctrl.if_id_en      = 1'b0;
                        w_ctrl.id_ex_en      = 1'b0;
                        w_ctrl.ex_mem_bubble = 1'b1;
                        w_load               = 1'b1;
                        w_next               = MD_BUSY;
                    end else if (ex_redirect) begin
                        // Redirect wins over load-use: the dependent instruction is squashed anyway.
                        w_ctrl.if_id_flush   = 1'b1;
                        w_ctrl.id_ex_bubble  = 1'b1;
                    end else if (w_load_use) begin
                        w_ctrl.pc_en         = 1'b0;
                        w_ctrl.if_id_en      = 1'b0;
                        w_ctrl.id_ex_bubble  = 1'b1;
                    end else begin
                        w_next = RUN;
                    end
                end
                MD_BUSY: begin
                    if (!w_md_zero) begin
                        w_ctrl.pc_en         = 1'b0;
                        w_ctrl.if_id_en      = 1'b0;
                        w_ctrl.id_ex_en      = 1'b0;
                        w_ctrl.ex_mem_bubble = 1'b1;
                        w_dec                = (w_md_cnt != '0);
                    end else begin
                        w_next = RUN;
                    end
                end
                MEM_WAIT: begin
                    if (dmem_ready) begin
                        w_next = RUN;
                    end else begin
                        w_ctrl.pc_en         = 1'b0;
                        w_ctrl.if_id_en      = 1'b0;
                        w_ctrl.id_ex_en      = 1'b0;
                        w_ctrl.ex_mem_en     = 1'b0;
                        w_ctrl.mem_wb_bubble = 1'b1;
                    end
                end
                default: begin
                    w_next = RUN;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next;
        end
    end

    // Saturating count of cycles with the PC held.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= 32'd0;
        end else if (!w_ctrl.pc_en) begin
            r_stall_cnt <= sat_inc32(r_stall_cnt);
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end

    assign pc_en         = w_ctrl.pc_en;
    assign if_id_en      = w_ctrl.if_id_en;
    assign if_id_flush   = w_ctrl.if_id_flush;
    assign id_ex_en      = w_ctrl.id_ex_en;
    assign id_ex_bubble  = w_ctrl.id_ex_bubble;
    assign ex_mem_en     = w_ctrl.ex_mem_en;
    assign ex_mem_bubble = w_ctrl.ex_mem_bubble;
    assign mem_wb_bubble = w_ctrl.mem_wb_bubble;
    assign md_go         = w_ctrl.md_go;
    assign stall_cnt     = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int MD_LAT = 8;
    localparam logic [8:0] DEF = 9'b110101000;
    localparam longint SAT = 64'h0000_0000_FFFF_FFFF;

    logic        clk;
    logic        reset;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        id_uses_rt, ex_mem_read, ex_redirect, ex_md_start, dmem_req, dmem_ready;
    logic        pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble;
    logic        ex_mem_en, ex_mem_bubble, mem_wb_bubble, md_go;
    logic [31:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    // Model state: m_k = cycle index of a mult/div in EX (0 = none), m_wait = memory freeze.
    int     m_k, n_k;
    bit     m_wait, n_wait;
    longint m_stall, n_stall;
    logic [8:0] exp_outs;

    wire [8:0] w_outs = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble,
                         ex_mem_en, ex_mem_bubble, mem_wb_bubble, md_go};

    pipe_hazard_ctrl #(.MD_LAT(MD_LAT)) dut (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_redirect(ex_redirect),
        .ex_md_start(ex_md_start), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush), .id_ex_en(id_ex_en),
        .id_ex_bubble(id_ex_bubble), .ex_mem_en(ex_mem_en), .ex_mem_bubble(ex_mem_bubble),
        .mem_wb_bubble(mem_wb_bubble), .md_go(md_go), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset) begin
            assert (!(ex_md_start && ex_redirect))
                else $error("FAIL illegal_md_redirect: ex_md_start and ex_redirect both high");
        end
    end

    task automatic model_eval();
        bit pe, ie, fl, ee, eb, me, mb, wb, go;
        pe = 1; ie = 1; fl = 0; ee = 1; eb = 0; me = 1; mb = 0; wb = 0; go = 0;
        n_k = m_k; n_wait = m_wait;
        if (reset) begin
            n_k = 0; n_wait = 0;
        end else if (m_k > 0) begin
            if (m_k < MD_LAT) begin pe = 0; ie = 0; ee = 0; mb = 1; n_k = m_k + 1; end
            else n_k = 0;
        end else if (m_wait) begin
            if (!dmem_ready) begin pe = 0; ie = 0; ee = 0; me = 0; wb = 1; end
            else n_wait = 0;
        end else if (dmem_req && !dmem_ready) begin
            pe = 0; ie = 0; ee = 0; me = 0; wb = 1; n_wait = 1;
        end else if (ex_md_start) begin
            go = 1; pe = 0; ie = 0; ee = 0; mb = 1; n_k = 2;
        end else if (ex_redirect) begin
            fl = 1; eb = 1;
        end else if (ex_mem_read && ex_rt != 5'd0 &&
                     (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt))) begin
            pe = 0; ie = 0; eb = 1;
        end
        exp_outs = {pe, ie, fl, ee, eb, me, mb, wb, go};
        if (reset) n_stall = 0;
        else if (!pe) n_stall = (m_stall >= SAT) ? SAT : m_stall + 1;
        else n_stall = m_stall;
    endtask

    task automatic tick();
        model_eval();
        @(posedge clk);
        m_k = n_k; m_wait = n_wait; m_stall = n_stall;
        #1;
    endtask

    task automatic clear_inputs();
        id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0; id_uses_rt = 1'b0; ex_mem_read = 1'b0;
        ex_redirect = 1'b0; ex_md_start = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic reset_dut();
        clear_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1; dmem_req = 1'b1; ex_md_start = 1'b1;
        ex_mem_read = 1'b1; ex_rt = 5'd3; id_rs = 5'd3;
        #1;
        checks++;
        if (w_outs !== DEF) begin errors++; $display("FAIL reset_outs: got %b want %b", w_outs, DEF); end
        tick();
        clear_inputs(); reset = 1'b0; #1;
        checks++;
        if (w_outs !== DEF) begin errors++; $display("FAIL post_reset_outs: got %b want %b", w_outs, DEF); end
        checks++;
        if (stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); end
    endtask

    task automatic test_load_use();
        reset_dut();
        ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; #1;
        checks++;
        if ({pc_en, if_id_en, id_ex_bubble, id_ex_en} !== 4'b0011) begin
            errors++; $display("FAIL load_use_rs: got %b want 0011", {pc_en, if_id_en, id_ex_bubble, id_ex_en});
        end
        tick();
        clear_inputs(); #1;
        checks++;
        if (pc_en !== 1'b1) begin errors++; $display("FAIL load_use_release: got %b want 1", pc_en); end
        checks++;
        if (stall_cnt !== 32'd1) begin errors++; $display("FAIL load_use_stall_cnt: got %0d want 1", stall_cnt); end
        ex_mem_read = 1'b1; ex_rt = 5'd7; id_rt = 5'd7; id_rs = 5'd2; id_uses_rt = 1'b1; #1;
        checks++;
        if (pc_en !== 1'b0) begin errors++; $display("FAIL load_use_rt: got %b want 0", pc_en); end
        id_uses_rt = 1'b0; #1;
        checks++;
        if (pc_en !== 1'b1) begin errors++; $display("FAIL load_use_rt_unused: got %b want 1", pc_en); end
        tick();
        clear_inputs();
    endtask

    task automatic test_zero_reg();
        reset_dut();
        ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b1; #1;
        checks++;
        if ({pc_en, id_ex_bubble} !== 2'b10) begin
            errors++; $display("FAIL zero_reg_no_stall: got %b want 10", {pc_en, id_ex_bubble});
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_redirect_load_use();
        logic [31:0] s0;
        reset_dut();
        s0 = stall_cnt;
        ex_redirect = 1'b1; ex_mem_read = 1'b1; ex_rt = 5'd9; id_rs = 5'd9; #1;
        checks++;
        if ({if_id_flush, id_ex_bubble, pc_en} !== 3'b111) begin
            errors++; $display("FAIL redirect_load_use: got %b want 111", {if_id_flush, id_ex_bubble, pc_en});
        end
        tick();
        clear_inputs(); #1;
        checks++;
        if (stall_cnt !== s0) begin errors++; $display("FAIL redirect_stall_cnt: got %0d want %0d", stall_cnt, s0); end
    endtask

    task automatic test_md();
        int n_go, n_hold;
        reset_dut();
        n_go = 0; n_hold = 0;
        ex_md_start = 1'b1; #1;
        for (int i = 1; i <= MD_LAT; i++) begin
            if (md_go === 1'b1) n_go++;
            if (id_ex_en === 1'b0) n_hold++;
            checks++;
            if (id_ex_en !== (i == MD_LAT)) begin
                errors++; $display("FAIL md_id_ex_en cycle %0d: got %b want %b", i, id_ex_en, (i == MD_LAT));
            end
            checks++;
            if (if_id_flush !== 1'b0) begin errors++; $display("FAIL md_ignores_redirect cycle %0d: got %b want 0", i, if_id_flush); end
            tick();
            ex_md_start = 1'b0;
            ex_redirect = (i + 1 < MD_LAT);
            #1;
        end
        checks++;
        if (n_go !== 1) begin errors++; $display("FAIL md_go_count: got %0d want 1", n_go); end
        checks++;
        if (n_hold !== MD_LAT - 1) begin errors++; $display("FAIL md_hold_count: got %0d want %0d", n_hold, MD_LAT - 1); end
        checks++;
        if (stall_cnt !== 32'(MD_LAT - 1)) begin errors++; $display("FAIL md_stall_cnt: got %0d want %0d", stall_cnt, MD_LAT - 1); end
        clear_inputs();
    endtask

    task automatic test_mem_wait();
        reset_dut();
        dmem_req = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ex_redirect = (i == 1); #1;
            checks++;
            if ({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_bubble, if_id_flush} !== 6'b000010) begin
                errors++; $display("FAIL mem_freeze cycle %0d: got %b want 000010", i,
                                   {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_bubble, if_id_flush});
            end
            tick();
        end
        ex_redirect = 1'b0; dmem_ready = 1'b1; #1;
        checks++;
        if (w_outs !== DEF) begin errors++; $display("FAIL mem_release: got %b want %b", w_outs, DEF); end
        tick();
        clear_inputs(); ex_redirect = 1'b1; #1;
        checks++;
        if (if_id_flush !== 1'b1) begin errors++; $display("FAIL mem_back_to_run: got %b want 1", if_id_flush); end
        checks++;
        if (stall_cnt !== 32'd3) begin errors++; $display("FAIL mem_stall_cnt: got %0d want 3", stall_cnt); end
        tick();
        clear_inputs();
    endtask

    task automatic test_reset_in_md();
        reset_dut();
        ex_md_start = 1'b1; #1;
        tick();
        ex_md_start = 1'b0;
        tick(); tick(); tick();
        reset = 1'b1; #1;
        checks++;
        if (w_outs !== DEF) begin errors++; $display("FAIL md_reset_outs: got %b want %b", w_outs, DEF); end
        tick();
        reset = 1'b0; #1;
        checks++;
        if (w_outs !== DEF) begin errors++; $display("FAIL md_after_reset_outs: got %b want %b", w_outs, DEF); end
        checks++;
        if (stall_cnt !== 32'd0) begin errors++; $display("FAIL md_after_reset_stall: got %0d want 0", stall_cnt); end
        for (int i = 0; i < MD_LAT; i++) begin
            tick();
            checks++;
            if ({pc_en, md_go} !== 2'b10) begin errors++; $display("FAIL md_abandoned cycle %0d: got %b want 10", i, {pc_en, md_go}); end
        end
    endtask

    task automatic test_random();
        reset_dut();
        for (int i = 0; i < 3000; i++) begin
            reset       = ($urandom_range(63) == 0);
            id_rs       = 5'($urandom_range(3));
            id_rt       = 5'($urandom_range(3));
            ex_rt       = 5'($urandom_range(3));
            id_uses_rt  = 1'($urandom_range(1));
            ex_mem_read = 1'($urandom_range(1));
            ex_md_start = ($urandom_range(15) == 0);
            ex_redirect = ex_md_start ? 1'b0 : ($urandom_range(3) == 0);
            dmem_req    = ($urandom_range(3) == 0);
            dmem_ready  = 1'($urandom_range(1));
            #1;
            model_eval();
            checks++;
            if (w_outs !== exp_outs) begin errors++; $display("FAIL rand_outs cycle %0d: got %b want %b", i, w_outs, exp_outs); end
            tick();
            checks++;
            if (stall_cnt !== m_stall[31:0]) begin
                errors++; $display("FAIL rand_stall_cnt cycle %0d: got %0d want %0d", i, stall_cnt, m_stall[31:0]);
            end
        end
        reset = 1'b0;
        clear_inputs();
    endtask

    initial begin
        m_k = 0; m_wait = 0; m_stall = 0;
        reset = 1'b1;
        clear_inputs();
        #1;
        test_reset();
        test_load_use();
        test_zero_reg();
        test_redirect_load_use();
        test_md();
        test_mem_wait();
        test_reset_in_md();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
